// File: rtl/ex_pkg.sv
// ex_pkg: shared constants and types for the execute stage.
// ALU control codes, FSM states, EX/MEM bundle, datapath width.
package ex_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_MUL  = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] store_data;
    logic [4:0]      rd;
    logic            reg_write;
  } ex_mem_t;

endpackage

// File: rtl/ex_mul_iter.sv
// ex_mul_iter: iterative shift-add multiplier, BITS multiplier
// bits retired per step; product is the low XLEN bits.
module ex_mul_iter
  import ex_pkg::*;
#(
  parameter int BITS = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            kill,
  input  logic            start,
  input  logic            step,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  output logic            last,
  output logic [XLEN-1:0] product
);

  localparam int CYCLES = XLEN / BITS;
  localparam int CW     = $clog2(CYCLES + 1);

  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] pp;

  // sum of shifted multiplicands for the low BITS of a
  always_comb begin
    pp = '0;
    for (int i = 0; i < BITS; i++) begin
      if (a_q[i]) pp = pp + (b_q << i);
    end
  end

  // load operands on start, retire BITS per step
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (kill) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (start) begin
      a_d   = a_in;
      b_d   = b_in;
      acc_d = '0;
      cnt_d = '0;
    end else if (step) begin
      a_d   = a_q >> BITS;
      b_d   = b_q << BITS;
      acc_d = acc_q + pp;
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign last    = step && (cnt_q == CW'(CYCLES - 1));
  assign product = acc_q;

  // multiplier state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: RISC-V execute stage, 1-cycle ALU plus iterative MUL.
// Optional operand forwarding from EX/MEM under EX_FWD_EN.
module ex_stage
  import ex_pkg::*;
#(
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic [XLEN-1:0] data_in_1,
  input  logic [XLEN-1:0] data_in_2,
  input  logic [XLEN-1:0] imm_in,
  input  logic            use_imm,
  input  logic [3:0]      ALU_ctrl_in,
  input  logic [4:0]      rd_in,
  input  logic            reg_write_in,
`ifdef EX_FWD_EN
  input  logic [4:0]      rs1_in,
  input  logic [4:0]      rs2_in,
`endif
  output logic            valid_out,
  input  logic            ready_in,
  output logic [XLEN-1:0] result_out,
  output logic [XLEN-1:0] store_data_out,
  output logic [4:0]      rd_out,
  output logic            reg_write_out,
  output logic            busy
);

  state_t          state_q, state_d;
  ex_mem_t         out_q, out_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] m_sd_q, m_sd_d;
  logic [4:0]      m_rd_q, m_rd_d;
  logic            m_rw_q, m_rw_d;

  logic [XLEN-1:0] src_a, src_b, op_b;
  logic [XLEN-1:0] alu_res, mul_prod;
  logic            out_free, accept, is_mul;
  logic            mul_start, mul_step, mul_last, mul_load;

`ifdef EX_FWD_EN
  logic fwd_ok;
  assign fwd_ok = valid_q && out_q.reg_write && (out_q.rd != 5'd0);
  assign src_a  = (fwd_ok && out_q.rd == rs1_in) ? out_q.result : data_in_1;
  assign src_b  = (fwd_ok && out_q.rd == rs2_in) ? out_q.result : data_in_2;
`else
  assign src_a = data_in_1;
  assign src_b = data_in_2;
`endif

  assign op_b     = use_imm ? imm_in : src_b;
  assign out_free = !valid_q || ready_in;
  assign is_mul   = (ALU_ctrl_in == ALU_MUL);
  assign accept   = valid_in && ready_out && !flush;

  // single-cycle ALU; codes 11-15 and MUL produce 0 here
  always_comb begin
    alu_res = '0;
    unique case (ALU_ctrl_in)
      ALU_ADD:  alu_res = src_a + op_b;
      ALU_SUB:  alu_res = src_a - op_b;
      ALU_AND:  alu_res = src_a & op_b;
      ALU_OR:   alu_res = src_a | op_b;
      ALU_XOR:  alu_res = src_a ^ op_b;
      ALU_SLL:  alu_res = src_a << op_b[4:0];
      ALU_SRL:  alu_res = src_a >> op_b[4:0];
      ALU_SRA:  alu_res = $unsigned($signed(src_a) >>> op_b[4:0]);
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}},
                           $signed(src_a) < $signed(op_b)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, src_a < op_b};
      ALU_MUL:  alu_res = '0;
      default:  alu_res = '0;
    endcase
  end

  ex_mul_iter #(
    .BITS(MUL_BITS_PER_CYCLE)
  ) u_mul (
    .clock   (clock),
    .reset   (reset),
    .kill    (flush),
    .start   (mul_start),
    .step    (mul_step),
    .a_in    (src_a),
    .b_in    (op_b),
    .last    (mul_last),
    .product (mul_prod)
  );

  // next state; flush aborts any multiply
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && is_mul) state_d = MUL;
      MUL:     if (mul_last) state_d = DONE;
      DONE:    if (out_free) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // FSM outputs and multiplier controls
  always_comb begin
    ready_out = (state_q == IDLE) && out_free;
    busy      = (state_q != IDLE);
    mul_start = accept && is_mul;
    mul_step  = (state_q == MUL);
    mul_load  = (state_q == DONE) && out_free && !flush;
  end

  // EX/MEM register and pending multiply metadata
  always_comb begin
    valid_d = valid_q;
    out_d   = out_q;
    m_sd_d  = m_sd_q;
    m_rd_d  = m_rd_q;
    m_rw_d  = m_rw_q;
    if (valid_q && ready_in) valid_d = 1'b0;
    if (mul_start) begin
      m_sd_d = src_b;
      m_rd_d = rd_in;
      m_rw_d = reg_write_in;
    end
    if (accept && !is_mul) begin
      valid_d          = 1'b1;
      out_d.result     = alu_res;
      out_d.store_data = src_b;
      out_d.rd         = rd_in;
      out_d.reg_write  = reg_write_in && (rd_in != 5'd0);
    end else if (mul_load) begin
      valid_d          = 1'b1;
      out_d.result     = mul_prod;
      out_d.store_data = m_sd_q;
      out_d.rd         = m_rd_q;
      out_d.reg_write  = m_rw_q && (m_rd_q != 5'd0);
    end
    if (flush) valid_d = 1'b0;
  end

  // stage registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      out_q   <= '0;
      m_sd_q  <= '0;
      m_rd_q  <= '0;
      m_rw_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      out_q   <= out_d;
      m_sd_q  <= m_sd_d;
      m_rd_q  <= m_rd_d;
      m_rw_q  <= m_rw_d;
    end
  end

  assign valid_out      = valid_q;
  assign result_out     = out_q.result;
  assign store_data_out = out_q.store_data;
  assign rd_out         = out_q.rd;
  assign reg_write_out  = out_q.reg_write;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed bench for ex_stage with a scoreboard model.
// Define EX_FWD_EN on both bench and RTL to cover forwarding.
module tb_ex_stage;
  import ex_pkg::*;

  localparam int MBPC = 1;
  localparam int MULC = 32 / MBPC;

  logic        clock = 1'b0;
  logic        reset, flush, valid_in, ready_out, use_imm;
  logic        reg_write_in, valid_out, ready_in;
  logic        reg_write_out, busy;
  logic [31:0] data_in_1, data_in_2, imm_in;
  logic [31:0] result_out, store_data_out;
  logic [3:0]  ALU_ctrl_in;
  logic [4:0]  rd_in, rd_out;
`ifdef EX_FWD_EN
  logic [4:0]  rs1_in, rs2_in;
`endif

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int last_wait;

  always #5 clock = ~clock;

  ex_stage #(.MUL_BITS_PER_CYCLE(MBPC)) dut (
    .clock          (clock),
    .reset          (reset),
    .flush          (flush),
    .valid_in       (valid_in),
    .ready_out      (ready_out),
    .data_in_1      (data_in_1),
    .data_in_2      (data_in_2),
    .imm_in         (imm_in),
    .use_imm        (use_imm),
    .ALU_ctrl_in    (ALU_ctrl_in),
    .rd_in          (rd_in),
    .reg_write_in   (reg_write_in),
`ifdef EX_FWD_EN
    .rs1_in         (rs1_in),
    .rs2_in         (rs2_in),
`endif
    .valid_out      (valid_out),
    .ready_in       (ready_in),
    .result_out     (result_out),
    .store_data_out (store_data_out),
    .rd_out         (rd_out),
    .reg_write_out  (reg_write_out),
    .busy           (busy)
  );

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h",
                  name, got, exp);
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] s;
    s = {27'd0, b[4:0]};
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a * (32'd1 << s);
      4'd6:  return a / (32'd1 << s);
      4'd7:  return a[31] ? ~((~a) >> s) : (a >> s);
      4'd8:  return (a[31] != b[31]) ? {31'd0, a[31]}
                                     : {31'd0, a < b};
      4'd9:  return {31'd0, a < b};
      4'd10: return a * b;
      default: return 32'd0;
    endcase
  endfunction

  typedef struct {
    logic [31:0] res;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw;
  } exp_t;

  exp_t q[$];

  logic        pst = 1'b0;
  logic [31:0] p_res, p_sd;
  logic [4:0]  p_rd;
  logic        p_rw;

  always @(negedge clock) begin
    exp_t e;
    logic [31:0] a, b, sd;
`ifdef EX_FWD_EN
    exp_t h;
    logic hv;
`endif
    if (pst) begin
      chk("stall_valid", valid_out, 1);
      chk("stall_result", result_out, p_res);
      chk("stall_store", store_data_out, p_sd);
      chk("stall_rd", rd_out, p_rd);
      chk("stall_rw", reg_write_out, p_rw);
    end
    pst   = !reset && !flush && valid_out && !ready_in;
    p_res = result_out;
    p_sd  = store_data_out;
    p_rd  = rd_out;
    p_rw  = reg_write_out;
    if (reset || flush) begin
      q.delete();
    end else begin
`ifdef EX_FWD_EN
      hv = valid_out && q.size() > 0;
      if (hv) h = q[0];
`endif
      if (valid_out) begin
        if (q.size() == 0) begin
          chk("sb_spurious", 1, 0);
        end else if (ready_in) begin
          e = q.pop_front();
          chk("sb_result", result_out, e.res);
          chk("sb_store", store_data_out, e.sd);
          chk("sb_rd", rd_out, e.rd);
          chk("sb_rw", reg_write_out, e.rw);
        end
      end
      if (valid_in && ready_out) begin
        a  = data_in_1;
        sd = data_in_2;
`ifdef EX_FWD_EN
        if (hv && h.rw && h.rd != 0 && h.rd == rs1_in) a = h.res;
        if (hv && h.rw && h.rd != 0 && h.rd == rs2_in) sd = h.res;
`endif
        b     = use_imm ? imm_in : sd;
        e.res = ref_alu(ALU_ctrl_in, a, b);
        e.sd  = sd;
        e.rd  = rd_in;
        e.rw  = reg_write_in && (rd_in != 0);
        q.push_back(e);
      end
    end
  end

  task automatic present(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm,
                         input logic ui, input logic [4:0] rd,
                         input logic rw);
    ALU_ctrl_in  = op;
    data_in_1    = a;
    data_in_2    = b;
    imm_in       = imm;
    use_imm      = ui;
    rd_in        = rd;
    reg_write_in = rw;
    valid_in     = 1'b1;
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    @(negedge clock);
    while (!ready_out && n < 200) begin
      n++;
      @(negedge clock);
    end
    if (!ready_out) chk("accept_timeout", 0, 1);
    last_wait = n;
    @(posedge clock);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm,
                       input logic ui, input logic [4:0] rd,
                       input logic rw);
    present(op, a, b, imm, ui, rd, rw);
    wait_accept();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    logic bad;
    reset = 1; flush = 0; valid_in = 0; ready_in = 1;
    data_in_1 = 0; data_in_2 = 0; imm_in = 0; use_imm = 0;
    ALU_ctrl_in = 0; rd_in = 0; reg_write_in = 0;
`ifdef EX_FWD_EN
    rs1_in = 0; rs2_in = 0;
`endif
    repeat (3) @(posedge clock);
    #1;
    chk("rst_valid", valid_out, 0);
    chk("rst_result", result_out, 0);
    chk("rst_store", store_data_out, 0);
    chk("rst_rd", rd_out, 0);
    chk("rst_rw", reg_write_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ready_out, 1);
    reset = 0;

    issue(ALU_ADD, 5, 7, 0, 0, 3, 1);
    chk("add_valid", valid_out, 1);
    chk("add_result", result_out, 12);
    chk("add_rd", rd_out, 3);
    chk("add_rw", reg_write_out, 1);
    @(posedge clock); #1;
    chk("add_drain", valid_out, 0);

    issue(ALU_SRA, 32'h8000_0000, 32'h1234, 4, 1, 9, 1);
    chk("sra_result", result_out, 32'hF800_0000);
    chk("sra_store", store_data_out, 32'h1234);
    issue(ALU_SLTU, 1, 32'hFFFF_FFFF, 0, 0, 4, 1);
    chk("sltu_result", result_out, 1);
    issue(ALU_SLT, 1, 32'hFFFF_FFFF, 0, 0, 4, 1);
    chk("slt_result", result_out, 0);
    issue(ALU_SUB, 3, 5, 0, 0, 4, 1);
    chk("sub_result", result_out, 32'hFFFF_FFFE);
    issue(ALU_SLL, 1, 0, 33, 1, 4, 1);
    chk("sll_result", result_out, 2);
    issue(ALU_ADD, 1, 1, 0, 0, 0, 1);
    chk("rd0_rw", reg_write_out, 0);
    chk("rd0_result", result_out, 2);
    issue(4'd12, 9, 9, 0, 0, 4, 1);
    chk("op12_valid", valid_out, 1);
    chk("op12_result", result_out, 0);

    issue(ALU_MUL, 32'hFFFF_FFFF, 3, 0, 0, 7, 1);
    ready_in = 0;
    n = 0; bad = 0;
    while (busy && n < 100) begin
      if (ready_out) bad = 1;
      n++;
      @(posedge clock); #1;
    end
    chk("mul_busy_cycles", n, MULC + 1);
    chk("mul_ready_low", bad, 0);
    chk("mul_valid", valid_out, 1);
    chk("mul_result", result_out, 32'hFFFF_FFFD);
    chk("mul_rd", rd_out, 7);
    chk("mul_stall_ready", ready_out, 0);
    repeat (3) @(posedge clock);
    #1;
    chk("mul_hold", result_out, 32'hFFFF_FFFD);
    ready_in = 1;
    @(posedge clock); #1;
    chk("mul_taken", valid_out, 0);

    for (int i = 0; i < 5; i++) begin
      issue(ALU_ADD, i * 100, i, 0, 0, 5'(i + 1), 1);
      if (i > 0) chk("b2b_nowait", last_wait, 0);
      chk("b2b_valid", valid_out, 1);
    end

    ready_in = 0;
    present(ALU_ADD, 1000, 1, 0, 0, 10, 1);
    repeat (3) begin
      @(negedge clock);
      chk("bp_ready", ready_out, 0);
      chk("bp_hold", result_out, 404);
    end
    @(posedge clock); #1;
    ready_in = 1;
    wait_accept();
    chk("bp_result", result_out, 1001);
    chk("bp_valid", valid_out, 1);

    issue(ALU_MUL, 7, 9, 0, 0, 8, 1);
    repeat (9) @(posedge clock);
    #1;
    flush = 1;
    present(ALU_ADD, 9, 9, 0, 0, 2, 1);
    @(posedge clock); #1;
    flush = 0; valid_in = 0;
    chk("fl_valid", valid_out, 0);
    chk("fl_busy", busy, 0);
    chk("fl_ready", ready_out, 1);
    issue(ALU_ADD, 2, 2, 0, 0, 6, 1);
    chk("fl_add_valid", valid_out, 1);
    chk("fl_add_result", result_out, 4);

    ready_in = 0;
    @(posedge clock); #1;
    flush = 1;
    @(posedge clock); #1;
    flush = 0;
    chk("fl_out_valid", valid_out, 0);
    ready_in = 1;

    issue(ALU_MUL, 5, 5, 0, 0, 11, 1);
    repeat (5) @(posedge clock);
    #1;
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
    chk("rm_valid", valid_out, 0);
    chk("rm_result", result_out, 0);
    chk("rm_store", store_data_out, 0);
    chk("rm_rd", rd_out, 0);
    chk("rm_busy", busy, 0);

    issue(ALU_XOR, 32'hF0F0, 32'hFF00, 0, 0, 1, 1);
    chk("xor_result", result_out, 32'h0FF0);
    issue(ALU_AND, 32'hF0F0, 32'hFF00, 0, 0, 1, 1);
    chk("and_result", result_out, 32'hF000);
    issue(ALU_SRL, 32'h8000_0000, 0, 31, 1, 1, 1);
    chk("srl_result", result_out, 1);
    issue(ALU_MUL, 32'h0001_0003, 32'h0000_0005, 0, 0, 12, 1);
    n = 0;
    while (!valid_out && n < 100) begin
      n++;
      @(posedge clock); #1;
    end
    chk("mul2_result", result_out, 32'h0005_000F);

`ifdef EX_FWD_EN
    issue(ALU_ADD, 2, 3, 0, 0, 5, 1);
    rs1_in = 5;
    issue(ALU_SUB, 0, 1, 0, 0, 6, 1);
    rs1_in = 0;
    chk("fwd_result", result_out, 4);
`endif

    repeat (3) @(posedge clock);
    #1;
    chk("sb_drain", q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
